// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply exponentiation controller that drives an
// external Montgomery multiplier over a start/done handshake.
module montgomery_exp #(
    parameter int WIDTH   = 1024,
    parameter int E_WIDTH = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_r,
    input  logic [WIDTH-1:0]   in_r2,
    output logic               mont_start,
    output logic [WIDTH-1:0]   mont_a,
    output logic [WIDTH-1:0]   mont_b,
    output logic [WIDTH-1:0]   mont_m,
    input  logic [WIDTH-1:0]   mont_result,
    input  logic               mont_done,
    output logic [WIDTH-1:0]   result,
    output logic               done,
    output logic               busy
);

    localparam int CW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, CONV, SQR, MUL, POST, FIN} state_t;

    state_t             state_q, state_d;
    logic               wait_q, wait_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   r2_q, r2_d;
    logic [WIDTH-1:0]   x_m_q, x_m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   m_reg_q, m_reg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [E_WIDTH-1:0] e_reg_q, e_reg_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wait_q   <= 1'b0;
            x_q      <= '0;
            r2_q     <= '0;
            x_m_q    <= '0;
            acc_q    <= '0;
            m_reg_q  <= '0;
            result_q <= '0;
            e_reg_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            x_q      <= x_d;
            r2_q     <= r2_d;
            x_m_q    <= x_m_d;
            acc_q    <= acc_d;
            m_reg_q  <= m_reg_d;
            result_q <= result_d;
            e_reg_q  <= e_reg_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        x_d      = x_q;
        r2_d     = r2_q;
        x_m_d    = x_m_q;
        acc_d    = acc_q;
        m_reg_d  = m_reg_q;
        result_d = result_q;
        e_reg_d  = e_reg_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    r2_d    = in_r2;
                    e_reg_d = in_e;
                    m_reg_d = in_m;
                    acc_d   = in_r;
                    cnt_d   = CW'(E_WIDTH - 1);
                    wait_d  = 1'b0;
                    state_d = CONV;
                end
            end
            CONV, SQR, MUL, POST: begin
                // mont_done only counts once the issue cycle has passed
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (mont_done) begin
                    wait_d = 1'b0;
                    case (state_q)
                        CONV: begin
                            x_m_d   = mont_result;
                            state_d = SQR;
                        end
                        POST: begin
                            result_d = mont_result;
                            state_d  = FIN;
                        end
                        default: begin
                            acc_d = mont_result;
                            if (state_q == SQR && e_reg_q[cnt_q]) begin
                                state_d = MUL;
                            end else if (cnt_q == '0) begin
                                state_d = POST;
                            end else begin
                                cnt_d   = cnt_q - CW'(1);
                                state_d = SQR;
                            end
                        end
                    endcase
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mont_start = 1'b0;
        mont_a     = '0;
        mont_b     = '0;
        done       = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            CONV: begin
                mont_start = !wait_q;
                mont_a     = x_q;
                mont_b     = r2_q;
            end
            SQR: begin
                mont_start = !wait_q;
                mont_a     = acc_q;
                mont_b     = acc_q;
            end
            MUL: begin
                mont_start = !wait_q;
                mont_a     = acc_q;
                mont_b     = x_m_q;
            end
            POST: begin
                mont_start = !wait_q;
                mont_a     = acc_q;
                mont_b     = ONE;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign mont_m = m_reg_q;
    assign result = result_q;

endmodule

// File: tb/tb_montgomery_exp.sv
// Bench for montgomery_exp (8-bit build) with a behavioural Montgomery
// multiplier of random latency and a scoreboard of expected results.
module tb_montgomery_exp;

    localparam int W  = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_m = '0, in_r = '0, in_r2 = '0;
    logic [EW-1:0] in_e = '0;
    logic          mont_start;
    logic [W-1:0]  mont_a, mont_b, mont_m;
    logic [W-1:0]  mont_result = '0;
    logic          mont_done = 1'b0;
    logic [W-1:0]  result;
    logic          done, busy;

    montgomery_exp #(.WIDTH(W), .E_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
        .mont_result(mont_result), .mont_done(mont_done),
        .result(result), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // a*b*2^-8 mod m by bit-serial reduction
    function automatic int redc(input int a, input int b, input int m);
        int t;
        t = a * b;
        for (int i = 0; i < W; i++) begin
            if (t % 2 == 1) t = t + m;
            t = t / 2;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    function automatic logic [7:0] modpow(input logic [7:0] x, input logic [7:0] e,
                                          input logic [7:0] m);
        int r;
        r = 1 % int'(m);
        for (int i = 0; i < int'(e); i++) r = (r * int'(x)) % int'(m);
        return 8'(r);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier
    int          lat_mode = 0;
    bit          mm_wait = 0;
    int          mm_cnt = 0;
    logic [W-1:0] cap_a, cap_b, cap_m, mm_res;
    int          n_starts = 0, sum_lat = 0, stab_err = 0;
    bit          stab_en = 1;

    always @(negedge clk) begin
        int lat;
        mont_done = 1'b0;
        if (mm_wait) begin
            if (stab_en && (mont_start || mont_a !== cap_a || mont_b !== cap_b || mont_m !== cap_m))
                stab_err++;
            mm_cnt--;
            if (mm_cnt == 0) begin
                mont_done   = 1'b1;
                mont_result = mm_res;
                mm_wait     = 0;
            end
        end else if (mont_start) begin
            cap_a = mont_a;
            cap_b = mont_b;
            cap_m = mont_m;
            n_starts++;
            lat = (lat_mode == 0) ? int'($urandom_range(1, 40)) : lat_mode;
            sum_lat += 1 + lat;
            mm_cnt  = lat;
            mm_wait = 1;
            mm_res  = 8'(redc(int'(cap_a), int'(cap_b), int'(cap_m)));
            mont_result = 8'($urandom);
        end
    end

    // Scoreboard
    typedef struct { logic [7:0] res; int pulses; } exp_t;
    exp_t sb_q[$];
    int done_cnt = 0, t_start = 0, base_starts = 0;

    always @(negedge clk) begin
        exp_t ex;
        if (resetn && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                ex = sb_q.pop_front();
                check("result", result, ex.res);
                check("mont_start_count", n_starts - base_starts, ex.pulses);
                check("latency", cyc - t_start + 1, sum_lat + 2);
                check("busy_at_done", busy, 1);
                $display("op done: result=%0d expected=%0d pulses=%0d cycles=%0d",
                         result, ex.res, n_starts - base_starts, cyc - t_start + 1);
            end
        end
    end

    task automatic do_start(input logic [7:0] x, input logic [7:0] e, input logic [7:0] m,
                            input bit accept);
        exp_t ex;
        @(negedge clk);
        in_x  = x;
        in_e  = e;
        in_m  = m;
        in_r  = 8'(256 % int'(m));
        in_r2 = 8'(65536 % int'(m));
        start = 1'b1;
        if (accept) begin
            t_start     = cyc;
            base_starts = n_starts;
            sum_lat     = 0;
            stab_err    = 0;
            ex.res      = modpow(x, e, m);
            ex.pulses   = EW + 2 + $countones(e);
            sb_q.push_back(ex);
        end
        @(negedge clk);
        start = 1'b0;
        in_x  = 8'($urandom);
        in_e  = 8'($urandom);
        in_m  = 8'($urandom);
        in_r  = 8'($urandom);
        in_r2 = 8'($urandom);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [7:0] m, x, e;
        int lat;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int d0, nst, k;
        vecs[0] = '{8'd247, 8'd5,   8'h00, 0};
        vecs[1] = '{8'd247, 8'd5,   8'h01, 0};
        vecs[2] = '{8'd247, 8'd200, 8'hA5, 0};
        vecs[3] = '{8'd251, 8'd2,   8'hFF, 1};
        vecs[4] = '{8'd191, 8'd190, 8'h80, 40};
        vecs[5] = '{8'd3,   8'd2,   8'h7F, 0};
        vecs[6] = '{8'd255, 8'd254, 8'h02, 3};
        vecs[7] = '{8'd247, 8'd0,   8'h13, 0};
        vecs[8] = '{8'd129, 8'd77,  8'hFE, 0};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mont_start", mont_start, 0);
        check("reset_result", result, 0);
        check("reset_mont_m", mont_m, 0);
        check("reset_mont_a", mont_a, 0);
        resetn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            lat_mode = vecs[i].lat;
            d0 = done_cnt;
            do_start(vecs[i].x, vecs[i].e, vecs[i].m, 1);
            check("mont_m_latched", mont_m, vecs[i].m);
            wait_done(d0, "vec");
            check("operands_stable", stab_err, 0);
            @(negedge clk);
            check("idle_after_done", busy, 0);
            check("done_single_cycle", done, 0);
            check("result_held", result, modpow(vecs[i].x, vecs[i].e, vecs[i].m));
        end

        // start during busy and in the FIN cycle are both ignored
        lat_mode = 0;
        d0 = done_cnt;
        do_start(8'd5, 8'hA5, 8'd247, 1);
        repeat (20) @(negedge clk);
        do_start(8'd7, 8'h3C, 8'd251, 0);
        k = 0;
        while (!done && k < 6000) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("fin_wait_timeout", 0, 1);
        start = 1'b1;
        in_x = 8'd9; in_e = 8'h55; in_m = 8'd251; in_r = 8'd5; in_r2 = 8'd25;
        @(negedge clk);
        start = 1'b0;
        nst = n_starts;
        repeat (60) @(negedge clk);
        check("fin_start_ignored_busy", busy, 0);
        check("fin_start_ignored_pulses", n_starts - nst, 0);
        check("fin_start_done_count", done_cnt - d0, 1);
        d0 = done_cnt;
        do_start(8'd3, 8'h0B, 8'd251, 1);
        wait_done(d0, "after_fin");

        // abort in the middle of a squaring, late mont_done must be ignored
        lat_mode = 20;
        d0 = done_cnt;
        do_start(8'd9, 8'hFF, 8'd247, 1);
        k = 0;
        while (n_starts - base_starts < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("abort_reached_sqr", n_starts - base_starts, 2);
        repeat (5) @(negedge clk);
        stab_en = 0;
        resetn  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sb_q.delete();
        nst = n_starts;
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_mont_m", mont_m, 0);
        check("abort_no_issue", n_starts - nst, 0);
        stab_en  = 1;
        lat_mode = 0;
        d0 = done_cnt;
        do_start(8'd10, 8'h07, 8'd191, 1);
        wait_done(d0, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/montgomery_exp.md
Name: montgomery_exp

Overview:
- Modular exponentiation controller that sits directly upstream of the Montgomery multiplier (montgomery2).
- Computes result = x^e mod M using left-to-right, fixed-iteration square-and-multiply.
- Sequences every multiplication through an external montgomery2 instance over its start/done handshake.
- Handles conversion into and out of the Montgomery domain, given host-supplied R mod M and R^2 mod M, where R = 2^WIDTH.

Parameters:
- WIDTH, 1024, operand/modulus width in bits; must match the multiplier.
- E_WIDTH, 1024, exponent width in bits; all E_WIDTH bits are always processed (constant time).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; samples in_x/in_e/in_m/in_r/in_r2 when idle.
- in_x  input  WIDTH  base, normal domain, < M.
- in_e  input  E_WIDTH  exponent.
- in_m  input  WIDTH  odd modulus M.
- in_r  input  WIDTH  R mod M (Montgomery one).
- in_r2  input  WIDTH  R^2 mod M.
- mont_start  output  1  one-cycle start pulse to the multiplier.
- mont_a  output  WIDTH  multiplier operand A.
- mont_b  output  WIDTH  multiplier operand B.
- mont_m  output  WIDTH  multiplier modulus.
- mont_result  input  WIDTH  multiplier result, A*B*R^-1 mod M.
- mont_done  input  1  multiplier completion pulse; mont_result valid in that cycle.
- result  output  WIDTH  x^e mod M, normal domain.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high from the accepted start until the done pulse, inclusive.

Behaviour:
- Single clock domain. Reset is synchronous and active-low; the clock is named clk and the reset resetn. All registers update on posedge clk only.
- Reset values: state=IDLE, mont_start=0, mont_a=mont_b=mont_m=0, result=0, done=0, busy=0, bit counter=0, internal regs x_m/acc/e_reg/m_reg=0.
- Operands are registered at start; inputs may change afterwards without effect.
- FSM states: IDLE, CONV, SQR, MUL, POST, FIN.
- Each multiplication step is split into two phases:
  - Issue phase, one cycle: mont_start=1 with mont_a/mont_b/mont_m driven.
  - Wait phase: mont_start=0, operands held stable, until mont_done=1.
  - mont_done is honoured only in a wait phase; otherwise it is ignored.
- IDLE:
  - start=1 latches all inputs, acc<=in_r, counter<=E_WIDTH-1, busy<=1, goes to CONV.
  - start while busy is ignored.
- CONV: A=in_x, B=in_r2. On done: x_m<=mont_result (x·R mod M), go to SQR.
- SQR: A=B=acc. On done: acc<=mont_result. If e_reg[counter]=1, go to MUL; else go to decision D.
- MUL: A=acc, B=x_m. On done: acc<=mont_result, go to decision D.
- Decision D:
  - If counter==0, go to POST.
  - Otherwise counter<=counter-1 and go to SQR.
- POST: A=acc, B=1 (zero-extended to WIDTH). On done: result<=mont_result, go to FIN.
- FIN: done=1 for exactly one cycle, busy<=0, return to IDLE.
- result holds its value until the next completed operation.
- Multiplication count: E_WIDTH squarings + popcount(e) multiplies + 2.
- Controller overhead: one issue cycle per multiplication plus the FIN cycle. Total latency = sum over all multiplications of (1 + multiplier latency), plus 2 cycles (start capture and FIN).
- Boundary conditions:
  - e=0 gives result=1 (for M>1).
  - MSB-first traversal: the bit at index E_WIDTH-1 is processed first.
  - The counter never wraps: the transition on counter==0 goes to POST.
- start arriving in the same cycle as FIN is ignored (busy is still high).
- resetn low mid-operation aborts immediately to reset values in the next cycle, with no done pulse. A mont_done arriving after the abort is ignored.
- mont_m equals m_reg from start until the next start.

Test Plan:
- E_WIDTH=8, M=0xF7 (WIDTH=8 test build), x=5, e=0x00 -> result=1; exactly 10 mont_start pulses; one done pulse.
- Same setup, e=0x01 -> result=5; 11 mont_start pulses.
- WIDTH=1024, E_WIDTH=1024, M=0xfb7348…ef518, random x and e, compared against a bignum model -> result matches; mont_start count = 1026 + popcount(e).
- Back-to-back: second start issued during busy and again in the FIN cycle -> both ignored; a start after done returns to IDLE behaviour and is accepted.
- resetn asserted mid-SQR, then the multiplier pulses mont_done -> no done pulse, state=IDLE, result=0, busy=0.
- Behavioural multiplier with random latency 1–40 cycles -> results are unchanged and the operands stay stable for the whole wait phase.
